axi_wr_order_arbiter: RTL and testbench

- Sits in each slave port of the AXI crossbar and shares that slave's AW and W channels between NUM_MST masters.
- Arbitrates AW requests round-robin and records the grant order in an outstanding-order FIFO.
- Steers W bursts strictly in AW grant order, with no interleaving, and checks burst length against AWLEN.

---
 rtl/axi_xbar_pkg.sv | 38 +++
 rtl/axi_ostd_fifo.sv | 56 +++++
 rtl/axi_wr_order_arbiter.sv | 162 ++++++++++++++++
 tb/tb_axi_wr_order_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_xbar_pkg.sv
// Shared types for the crossbar slave-port write path: AW FSM states, order-FIFO entry, RR search.
// Purely combinational helpers; no latency, no backpressure.
package axi_xbar_pkg;

    localparam int MAX_MST   = 8;
    localparam int ORD_IDX_W = 3;

    typedef enum logic [0:0] {
        AW_IDLE,
        AW_HOLD
    } aw_state_e;

    typedef struct packed {
        logic [ORD_IDX_W-1:0] idx;
        logic [3:0]           len;
    } ord_entry_t;

    // Returns {found, index} of the first set request at or after ptr, wrapping at n.
    function automatic logic [ORD_IDX_W:0] rr_find_first(
        input logic [MAX_MST-1:0]   req,
        input logic [ORD_IDX_W-1:0] ptr,
        input int                   n
    );
        logic [ORD_IDX_W:0] res;
        int                 pos;
        res = '0;
        for (int k = MAX_MST - 1; k >= 0; k--) begin
            if (k < n) begin
                pos = (int'(ptr) + k) % n;
                if (req[pos]) begin
                    res = {1'b1, pos[ORD_IDX_W-1:0]};
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_ostd_fifo.sv
// Order FIFO of granted AW entries; a push is visible at head the cycle after it is taken.
// Push is ignored when full and pop when empty; full-with-pop does not bypass.
module axi_ostd_fifo #(
    parameter int DEPTH = 4,
    parameter int ENT_W = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [ENT_W-1:0]       push_dat,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [ENT_W-1:0]       head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             do_push, do_pop;

    always_comb begin
        full     = (cnt_q == (PTR_W+1)'(DEPTH));
        empty    = (cnt_q == '0);
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        cnt_d    = cnt_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        count    = cnt_q;
        head     = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/axi_wr_order_arbiter.sv
// Shares one slave's AW/W channels between masters: round-robin AW grant, W steered in grant order.
// AW and W muxes are combinational; W of an ungranted master stalls, AW stalls while the order FIFO is full.
module axi_wr_order_arbiter
    import axi_xbar_pkg::*;
#(
    parameter int NUM_MST    = 4,
    parameter int AWCH_W     = 53,
    parameter int WCH_W      = 47,
    parameter int OSTD_DEPTH = 4
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [NUM_MST-1:0]          s_awvalid,
    output logic [NUM_MST-1:0]          s_awready,
    input  logic [NUM_MST*4-1:0]        s_awlen,
    input  logic [NUM_MST*AWCH_W-1:0]   s_awpayload,
    output logic                        m_awvalid,
    input  logic                        m_awready,
    output logic [3:0]                  m_awlen,
    output logic [AWCH_W-1:0]           m_awpayload,
    input  logic [NUM_MST-1:0]          s_wvalid,
    output logic [NUM_MST-1:0]          s_wready,
    input  logic [NUM_MST-1:0]          s_wlast,
    input  logic [NUM_MST*WCH_W-1:0]    s_wpayload,
    output logic                        m_wvalid,
    input  logic                        m_wready,
    output logic                        m_wlast,
    output logic [WCH_W-1:0]            m_wpayload,
    output logic [$clog2(OSTD_DEPTH):0] ostd_cnt,
    output logic                        err_wlast
);

    localparam int IDX_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

    aw_state_e          state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;
    logic [3:0]         beat_cnt_q, beat_cnt_d;
    logic               err_wlast_q, err_wlast_d;
    logic               rst_done_q;

    logic [ORD_IDX_W:0] rr_res;
    logic [IDX_W-1:0]   aw_sel, w_sel;
    logic               aw_vld, aw_hs, w_act, w_hs;
    logic               fifo_full, fifo_empty, push, pop;
    ord_entry_t         head, push_ent;
    logic               unused_bits;

    always_comb begin
        rr_res = rr_find_first(MAX_MST'(s_awvalid), ORD_IDX_W'(rr_ptr_q), NUM_MST);
        aw_sel = rr_res[IDX_W-1:0];
        aw_vld = rr_res[ORD_IDX_W] & ~fifo_full;
        // A held grant ignores other requests and does not re-check full: nothing else can push.
        if (state_q == AW_HOLD) begin
            aw_sel = lock_idx_q;
            aw_vld = s_awvalid[lock_idx_q];
        end
        aw_vld = aw_vld & rst_done_q;
        aw_hs  = aw_vld & m_awready;
    end

    always_comb begin
        m_awvalid   = aw_vld;
        m_awlen     = '0;
        m_awpayload = '0;
        s_awready   = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (aw_vld && aw_sel == IDX_W'(i)) begin
                m_awlen      = s_awlen[i*4 +: 4];
                m_awpayload  = s_awpayload[i*AWCH_W +: AWCH_W];
                s_awready[i] = m_awready;
            end
        end
        push         = aw_hs;
        push_ent.idx = ORD_IDX_W'(aw_sel);
        push_ent.len = m_awlen;
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        if (aw_hs) begin
            state_d  = AW_IDLE;
            rr_ptr_d = (aw_sel == IDX_W'(NUM_MST - 1)) ? '0 : aw_sel + 1'b1;
        end else if (state_q == AW_IDLE && aw_vld) begin
            state_d    = AW_HOLD;
            lock_idx_d = aw_sel;
        end
    end

    axi_ostd_fifo #(
        .DEPTH (OSTD_DEPTH),
        .ENT_W ($bits(ord_entry_t))
    ) u_ostd_fifo (
        .clk      (aclk),
        .rst_n    (aresetn),
        .push     (push),
        .push_dat (push_ent),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (ostd_cnt),
        .head     (head)
    );

    always_comb begin
        w_sel      = head.idx[IDX_W-1:0];
        w_act      = ~fifo_empty & rst_done_q;
        m_wvalid   = 1'b0;
        m_wlast    = 1'b0;
        m_wpayload = '0;
        s_wready   = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (w_act && w_sel == IDX_W'(i)) begin
                m_wvalid    = s_wvalid[i];
                m_wlast     = s_wlast[i];
                m_wpayload  = s_wpayload[i*WCH_W +: WCH_W];
                s_wready[i] = m_wready;
            end
        end
        w_hs = m_wvalid & m_wready;
        pop  = w_hs & m_wlast;
    end

    // beat_cnt counts beats already taken, so the last beat of a burst sees beat_cnt == len.
    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        err_wlast_d = err_wlast_q;
        if (w_hs) begin
            if (m_wlast) begin
                beat_cnt_d = '0;
            end else if (beat_cnt_q != 4'hF) begin
                beat_cnt_d = beat_cnt_q + 4'd1;
            end
            if (m_wlast != (beat_cnt_q == head.len)) begin
                err_wlast_d = 1'b1;
            end
        end
        err_wlast   = err_wlast_q;
        unused_bits = ^{head.idx, rr_res};
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= AW_IDLE;
            rr_ptr_q    <= '0;
            lock_idx_q  <= '0;
            beat_cnt_q  <= '0;
            err_wlast_q <= 1'b0;
            rst_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_idx_q  <= lock_idx_d;
            beat_cnt_q  <= beat_cnt_d;
            err_wlast_q <= err_wlast_d;
            rst_done_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_wr_order_arbiter.sv
// Directed bench for axi_wr_order_arbiter: grant order, W steering, FIFO full, wlast errors, reset.
module tb_axi_wr_order_arbiter;

    localparam int N  = 4;
    localparam int AW = 53;
    localparam int WW = 47;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [N-1:0]      s_awvalid, s_awready;
    logic [N*4-1:0]    s_awlen;
    logic [N*AW-1:0]   s_awpayload;
    logic              m_awvalid, m_awready;
    logic [3:0]        m_awlen;
    logic [AW-1:0]     m_awpayload;
    logic [N-1:0]      s_wvalid, s_wready, s_wlast;
    logic [N*WW-1:0]   s_wpayload;
    logic              m_wvalid, m_wready, m_wlast;
    logic [WW-1:0]     m_wpayload;
    logic [2:0]        ostd_cnt;
    logic              err_wlast;

    int n_vec = 0;
    int n_err = 0;

    axi_wr_order_arbiter dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .s_awvalid   (s_awvalid),
        .s_awready   (s_awready),
        .s_awlen     (s_awlen),
        .s_awpayload (s_awpayload),
        .m_awvalid   (m_awvalid),
        .m_awready   (m_awready),
        .m_awlen     (m_awlen),
        .m_awpayload (m_awpayload),
        .s_wvalid    (s_wvalid),
        .s_wready    (s_wready),
        .s_wlast     (s_wlast),
        .s_wpayload  (s_wpayload),
        .m_wvalid    (m_wvalid),
        .m_wready    (m_wready),
        .m_wlast     (m_wlast),
        .m_wpayload  (m_wpayload),
        .ostd_cnt    (ostd_cnt),
        .err_wlast   (err_wlast)
    );

    always #5 aclk = ~aclk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [AW-1:0] aw_pl(input int i);
        return AW'(64'hA5A5_0000_0000 + 64'(i));
    endfunction

    function automatic logic [WW-1:0] w_pl(input int i, input int b);
        return WW'(32'h7000_0000 + i * 256 + b);
    endfunction

    task automatic do_reset();
        aresetn   = 1'b0;
        s_awvalid = '0;
        s_awlen   = '0;
        s_wvalid  = '0;
        s_wlast   = '0;
        m_awready = 1'b1;
        m_wready  = 1'b1;
        tick();
        aresetn = 1'b1;
        tick();
    endtask

    initial begin
        aresetn    = 1'b0;
        s_awvalid  = '0;
        s_awlen    = '0;
        s_wvalid   = '0;
        s_wlast    = '0;
        s_wpayload = '0;
        m_awready  = 1'b0;
        m_wready   = 1'b0;
        for (int i = 0; i < N; i++) s_awpayload[i*AW +: AW] = aw_pl(i);
        #2;
        chk("rst_awvalid", m_awvalid, 0);
        chk("rst_wvalid", m_wvalid, 0);
        chk("rst_ostd", ostd_cnt, 0);
        chk("rst_err", err_wlast, 0);

        // 1: single 4-beat burst from master 0; early W stalls until the AW is recorded
        do_reset();
        s_awlen[3:0] = 4'd3;
        s_awvalid    = 4'b0001;
        s_wvalid     = 4'b0001;
        s_wpayload[0 +: WW] = w_pl(0, 0);
        #1;
        chk("t1_awvalid", m_awvalid, 1);
        chk("t1_awlen", m_awlen, 3);
        chk("t1_awpl", m_awpayload, aw_pl(0));
        chk("t1_awready", s_awready, 4'b0001);
        chk("t1_wstall", s_wready, 0);
        tick();
        s_awvalid = '0;
        for (int b = 0; b < 4; b++) begin
            s_wpayload[0 +: WW] = w_pl(0, b);
            s_wlast[0] = (b == 3);
            #1;
            chk("t1_wvalid", m_wvalid, 1);
            chk("t1_wpl", m_wpayload, w_pl(0, b));
            chk("t1_wlast", m_wlast, (b == 3) ? 1 : 0);
            chk("t1_ostd", ostd_cnt, 1);
            tick();
        end
        s_wvalid = '0;
        s_wlast  = '0;
        #1;
        chk("t1_ostd_end", ostd_cnt, 0);
        chk("t1_err", err_wlast, 0);

        // 2: four simultaneous single-beat requests, grants and W in order 0..3
        do_reset();
        s_awvalid = 4'hF;
        for (int k = 0; k < N; k++) begin
            #1;
            chk("t2_awgrant", s_awready, 64'(1) << k);
            tick();
            s_awvalid[k] = 1'b0;
        end
        #1;
        chk("t2_ostd", ostd_cnt, 4);
        chk("t2_awvalid_idle", m_awvalid, 0);
        s_wvalid = 4'hF;
        s_wlast  = 4'hF;
        for (int i = 0; i < N; i++) s_wpayload[i*WW +: WW] = w_pl(i, 0);
        for (int k = 0; k < N; k++) begin
            #1;
            chk("t2_wgrant", s_wready, 64'(1) << k);
            chk("t2_wpl", m_wpayload, w_pl(k, 0));
            tick();
        end
        s_wvalid = '0;
        s_wlast  = '0;
        #1;
        chk("t2_ostd_end", ostd_cnt, 0);

        // 3: grant locked on master 2 while master 1 waits; rr pointer then skips idle 3 and 0
        do_reset();
        m_awready = 1'b0;
        s_awvalid = 4'b0100;
        #1;
        chk("t3_awvalid", m_awvalid, 1);
        chk("t3_awpl0", m_awpayload, aw_pl(2));
        chk("t3_awready0", s_awready, 0);
        tick();
        s_awvalid = 4'b0110;
        repeat (2) begin
            #1;
            chk("t3_awpl_hold", m_awpayload, aw_pl(2));
            tick();
        end
        m_awready = 1'b1;
        #1;
        chk("t3_hs2", s_awready, 4'b0100);
        tick();
        s_awvalid = 4'b0010;
        #1;
        chk("t3_hs1", s_awready, 4'b0010);
        tick();
        s_awvalid = '0;
        s_wvalid  = 4'b0110;
        s_wlast   = 4'b0110;
        s_wpayload[1*WW +: WW] = w_pl(1, 0);
        s_wpayload[2*WW +: WW] = w_pl(2, 0);
        #1;
        chk("t3_w_first", s_wready, 4'b0100);
        tick();
        chk("t3_w_second", s_wready, 4'b0010);
        tick();
        s_wvalid = '0;
        s_wlast  = '0;
        #1;
        chk("t3_ostd_end", ostd_cnt, 0);

        // 4: FIFO full blocks the fifth AW; a pop frees space only on the next cycle
        do_reset();
        m_wready  = 1'b0;
        s_awvalid = 4'b0001;
        repeat (4) tick();
        s_wvalid = 4'b0001;
        s_wlast  = 4'b0001;
        s_wpayload[0 +: WW] = w_pl(0, 0);
        #1;
        chk("t4_ostd_full", ostd_cnt, 4);
        chk("t4_awvalid_full", m_awvalid, 0);
        chk("t4_awready_full", s_awready, 0);
        chk("t4_wvalid", m_wvalid, 1);
        chk("t4_wready_low", s_wready, 0);
        tick();
        m_wready = 1'b1;
        #1;
        chk("t4_no_bypass", m_awvalid, 0);
        chk("t4_wready", s_wready, 4'b0001);
        tick();
        m_wready = 1'b0;
        #1;
        chk("t4_ostd_pop", ostd_cnt, 3);
        chk("t4_awvalid_again", m_awvalid, 1);
        tick();
        s_awvalid = '0;
        #1;
        chk("t4_ostd_refill", ostd_cnt, 4);
        m_wready = 1'b1;
        repeat (4) tick();
        s_wvalid = '0;
        s_wlast  = '0;
        #1;
        chk("t4_ostd_end", ostd_cnt, 0);
        chk("t4_err", err_wlast, 0);

        // 5: early wlast on a 4-beat burst sets a sticky error
        do_reset();
        s_awlen[3:0] = 4'd3;
        s_awvalid    = 4'b0001;
        tick();
        s_awvalid = '0;
        s_wvalid  = 4'b0001;
        s_wlast   = 4'b0000;
        #1;
        chk("t5_err_pre", err_wlast, 0);
        tick();
        s_wlast = 4'b0001;
        #1;
        chk("t5_wlast", m_wlast, 1);
        tick();
        s_wvalid = '0;
        s_wlast  = '0;
        #1;
        chk("t5_ostd", ostd_cnt, 0);
        chk("t5_err_set", err_wlast, 1);
        s_awlen[3:0] = 4'd0;
        s_awvalid    = 4'b0001;
        tick();
        s_awvalid = '0;
        s_wvalid  = 4'b0001;
        s_wlast   = 4'b0001;
        tick();
        s_wvalid = '0;
        s_wlast  = '0;
        #1;
        chk("t5_ostd_ok", ostd_cnt, 0);
        chk("t5_err_sticky", err_wlast, 1);

        // 6: reset during beat 2 discards the burst; first grant afterwards restarts at master 0
        do_reset();
        s_awlen[3:0] = 4'd3;
        s_awvalid    = 4'b0001;
        tick();
        s_awvalid = '0;
        s_wvalid  = 4'b0001;
        tick();
        aresetn   = 1'b0;
        s_awvalid = 4'b0011;
        #1;
        chk("t6_wvalid_rst", m_wvalid, 0);
        chk("t6_wready_rst", s_wready, 0);
        chk("t6_ostd_rst", ostd_cnt, 0);
        chk("t6_awvalid_rst", m_awvalid, 0);
        chk("t6_awready_rst", s_awready, 0);
        tick();
        aresetn  = 1'b1;
        s_wvalid = '0;
        #1;
        chk("t6_awvalid_wait", m_awvalid, 0);
        chk("t6_awready_wait", s_awready, 0);
        tick();
        chk("t6_awvalid_go", m_awvalid, 1);
        chk("t6_grant0", s_awready, 4'b0001);
        tick();
        s_awvalid = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
